// File: rtl/param_pattern_generator.sv
// -----------------------------------------------------------------------------
// param_pattern_generator
//   Video test-pattern source. It walks a true X/Y raster, one pixel for each
//   cycle in which the sink accepts the current pixel. It emits checkerboard,
//   vertical-bar, horizontal-bar or solid colour patterns. Tile geometry
//   follows the raster position, and the pattern mode is latched only at
//   frame boundaries.
//
// Ports
//   Clock       in   1   system clock, rising edge
//   Reset       in   1   synchronous, active-high; zeroes raster, loads mode
//   VideoReady  in   1   sink consumed the current pixel; advance raster
//   Mode        in   2   requested pattern: 0 checker, 1 vbars, 2 hbars, 3 solid
//   video       out  24  current pixel {R,G,B}, zero latency from state
//   FrameStart  out  1   current pixel is (0,0)
//   LineStart   out  1   current pixel has x == 0
//   ActiveMode  out  2   mode in force for the current frame
// -----------------------------------------------------------------------------
module param_pattern_generator #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned TILE_W   = 80,
  parameter int unsigned TILE_H   = 50,
  parameter logic [23:0] COLOR_A  = {8'd142, 8'd68, 8'd173},
  parameter logic [23:0] COLOR_B  = {8'd44, 8'd62, 8'd80},
  parameter logic [23:0] COLOR_C  = {8'd22, 8'd160, 8'd133},
  parameter logic [23:0] COLOR_D  = {8'd41, 8'd128, 8'd185}
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        VideoReady,
  input  logic [1:0]  Mode,
  output logic [23:0] video,
  output logic        FrameStart,
  output logic        LineStart,
  output logic [1:0]  ActiveMode
);

  localparam int unsigned COLS = (H_ACTIVE + TILE_W - 1) / TILE_W;
  localparam int unsigned ROWS = (V_ACTIVE + TILE_H - 1) / TILE_H;

  localparam int unsigned XW  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned TXW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int unsigned TYW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  // Tile indices keep at least two bits so the bar modes can always read [1:0].
  localparam int unsigned CW  = (COLS > 4) ? $clog2(COLS) : 2;
  localparam int unsigned RW  = (ROWS > 4) ? $clog2(ROWS) : 2;

  localparam logic [XW-1:0]  XLast  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]  YLast  = YW'(V_ACTIVE - 1);
  localparam logic [TXW-1:0] TxLast = TXW'(TILE_W - 1);
  localparam logic [TYW-1:0] TyLast = TYW'(TILE_H - 1);

  logic [XW-1:0]  r_x,    w_x_nxt;
  logic [YW-1:0]  r_y,    w_y_nxt;
  logic [TXW-1:0] r_tx,   w_tx_nxt;
  logic [TYW-1:0] r_ty,   w_ty_nxt;
  logic [CW-1:0]  r_col,  w_col_nxt;
  logic [RW-1:0]  r_row,  w_row_nxt;
  logic [1:0]     r_mode, w_mode_nxt;
  logic [1:0]     w_idx;

  // Raster advance. Line wrap overrides the in-line tile step, and frame wrap
  // overrides the line step.
  always_comb begin
    w_x_nxt    = r_x;
    w_y_nxt    = r_y;
    w_tx_nxt   = r_tx;
    w_ty_nxt   = r_ty;
    w_col_nxt  = r_col;
    w_row_nxt  = r_row;
    w_mode_nxt = r_mode;
    if (VideoReady) begin
      if (r_x == XLast) begin
        w_x_nxt   = '0;
        w_tx_nxt  = '0;
        w_col_nxt = '0;
        if (r_y == YLast) begin
          w_y_nxt    = '0;
          w_ty_nxt   = '0;
          w_row_nxt  = '0;
          w_mode_nxt = Mode;
        end else begin
          w_y_nxt = r_y + 1'b1;
          if (r_ty == TyLast) begin
            w_ty_nxt  = '0;
            w_row_nxt = r_row + 1'b1;
          end else begin
            w_ty_nxt = r_ty + 1'b1;
          end
        end
      end else begin
        w_x_nxt = r_x + 1'b1;
        if (r_tx == TxLast) begin
          w_tx_nxt  = '0;
          w_col_nxt = r_col + 1'b1;
        end else begin
          w_tx_nxt = r_tx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_tx   <= '0;
      r_ty   <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_mode <= Mode;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_tx   <= w_tx_nxt;
      r_ty   <= w_ty_nxt;
      r_col  <= w_col_nxt;
      r_row  <= w_row_nxt;
      r_mode <= w_mode_nxt;
    end
  end

  // Colour index from tile position and the latched mode.
  always_comb begin
    w_idx = 2'd0;
    unique case (r_mode)
      2'd0:    w_idx = {r_row[0], r_col[0]};
      2'd1:    w_idx = r_col[1:0];
      2'd2:    w_idx = r_row[1:0];
      default: w_idx = 2'd0;
    endcase
  end

  always_comb begin
    video = COLOR_A;
    unique case (w_idx)
      2'd0:    video = COLOR_A;
      2'd1:    video = COLOR_B;
      2'd2:    video = COLOR_C;
      default: video = COLOR_D;
    endcase
  end

  assign LineStart  = (r_x == '0);
  assign FrameStart = (r_x == '0) && (r_y == '0);
  assign ActiveMode = r_mode;

endmodule

// File: tb/tb_param_pattern_generator.sv
// -----------------------------------------------------------------------------
// tb_param_pattern_generator
//   Directed and random stimulus for two instances: an 8x4 raster with 2x2
//   tiles, and a 7x3 raster with 3x1 tiles. The reference model keeps a linear
//   pixel index per instance. It derives x/y, tile and colour with division
//   and modulo.
// -----------------------------------------------------------------------------
module tb_param_pattern_generator;

  localparam logic [23:0] CA = {8'd142, 8'd68, 8'd173};
  localparam logic [23:0] CB = {8'd44, 8'd62, 8'd80};
  localparam logic [23:0] CC = {8'd22, 8'd160, 8'd133};
  localparam logic [23:0] CD = {8'd41, 8'd128, 8'd185};

  localparam int H1 = 8, V1 = 4, TW1 = 2, TH1 = 2;
  localparam int H2 = 7, V2 = 3, TW2 = 3, TH2 = 1;

  logic        Clock;
  logic        rst1, vr1, rst2, vr2;
  logic [1:0]  mode1, mode2;
  logic [23:0] video1, video2;
  logic        fs1, ls1, fs2, ls2;
  logic [1:0]  am1, am2;

  int checks = 0;
  int errors = 0;

  int m1_pos, m1_mode, m2_pos, m2_mode;

  param_pattern_generator #(
    .H_ACTIVE(H1), .V_ACTIVE(V1), .TILE_W(TW1), .TILE_H(TH1),
    .COLOR_A(CA), .COLOR_B(CB), .COLOR_C(CC), .COLOR_D(CD)
  ) u_dut1 (
    .Clock(Clock), .Reset(rst1), .VideoReady(vr1), .Mode(mode1),
    .video(video1), .FrameStart(fs1), .LineStart(ls1), .ActiveMode(am1)
  );

  param_pattern_generator #(
    .H_ACTIVE(H2), .V_ACTIVE(V2), .TILE_W(TW2), .TILE_H(TH2),
    .COLOR_A(CA), .COLOR_B(CB), .COLOR_C(CC), .COLOR_D(CD)
  ) u_dut2 (
    .Clock(Clock), .Reset(rst2), .VideoReady(vr2), .Mode(mode2),
    .video(video2), .FrameStart(fs2), .LineStart(ls2), .ActiveMode(am2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [23:0] exp_px(int mode, int x, int y, int tw, int th);
    int col, row, idx;
    col = x / tw;
    row = y / th;
    case (mode)
      0:       idx = (row % 2) * 2 + (col % 2);
      1:       idx = col % 4;
      2:       idx = row % 4;
      default: idx = 0;
    endcase
    case (idx)
      0:       return CA;
      1:       return CB;
      2:       return CC;
      default: return CD;
    endcase
  endfunction

  task automatic chk(string tag, logic [23:0] got, logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int x1, y1, x2, y2;
    x1 = m1_pos % H1;
    y1 = m1_pos / H1;
    x2 = m2_pos % H2;
    y2 = m2_pos / H2;
    chk("dut1_video", video1, exp_px(m1_mode, x1, y1, TW1, TH1));
    chk("dut1_frame_start", 24'(fs1), 24'((x1 == 0 && y1 == 0) ? 1 : 0));
    chk("dut1_line_start", 24'(ls1), 24'((x1 == 0) ? 1 : 0));
    chk("dut1_active_mode", 24'(am1), 24'(m1_mode));
    chk("dut2_video", video2, exp_px(m2_mode, x2, y2, TW2, TH2));
    chk("dut2_frame_start", 24'(fs2), 24'((x2 == 0 && y2 == 0) ? 1 : 0));
    chk("dut2_line_start", 24'(ls2), 24'((x2 == 0) ? 1 : 0));
    chk("dut2_active_mode", 24'(am2), 24'(m2_mode));
  endtask

  // One clock: update models with inputs in force at the edge, then check.
  task automatic tick();
    @(posedge Clock);
    if (rst1) begin
      m1_pos  = 0;
      m1_mode = int'(mode1);
    end else if (vr1) begin
      m1_pos++;
      if (m1_pos == H1 * V1) begin
        m1_pos  = 0;
        m1_mode = int'(mode1);
      end
    end
    if (rst2) begin
      m2_pos  = 0;
      m2_mode = int'(mode2);
    end else if (vr2) begin
      m2_pos++;
      if (m2_pos == H2 * V2) begin
        m2_pos  = 0;
        m2_mode = int'(mode2);
      end
    end
    #1;
    check_all();
  endtask

  task automatic run_to(int target);
    for (int i = 0; i < 200 && m1_pos != target; i++) tick();
  endtask

  initial begin
    m1_pos = 0; m1_mode = 0; m2_pos = 0; m2_mode = 1;
    rst1 = 1'b1; vr1 = 1'b1; mode1 = 2'd0;
    rst2 = 1'b1; vr2 = 1'b1; mode2 = 2'd1;
    #1;
    // Reset with VideoReady high: reset wins.
    tick();
    tick();
    rst1 = 1'b0;
    rst2 = 1'b0;

    // Checker frame, then the frame wrap back to (0,0).
    for (int i = 0; i < 32; i++) tick();

    // Vertical bars, then horizontal bars (each latched at a frame wrap).
    mode1 = 2'd1;
    for (int i = 0; i < 64; i++) tick();
    mode1 = 2'd2;
    for (int i = 0; i < 64; i++) tick();

    // Checker again, then switch to solid mid-frame at pixel 13.
    mode1 = 2'd0;
    run_to(0);
    for (int i = 0; i < 32; i++) tick();
    run_to(13);
    mode1 = 2'd3;
    for (int i = 0; i < 51; i++) tick();

    // Random VideoReady, checker pattern.
    mode1 = 2'd0;
    for (int i = 0; i < 300; i++) begin
      vr1 = 1'($urandom_range(0, 1));
      vr2 = 1'($urandom_range(0, 1));
      tick();
    end
    vr1 = 1'b1;
    vr2 = 1'b1;

    // Reset mid-frame at pixel 19 with VideoReady still high.
    run_to(0);
    run_to(19);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
